mips_alu_mul_div: RTL and testbench

MIPS_ALU_MUL_DIV -- requirements
Module: mips_alu_mul_div

---
 rtl/mips_alu_mul_div_pkg.sv | 67 ++++++
 rtl/mips_alu_mul_div_step.sv | 62 ++++++
 rtl/mips_alu_mul_div.sv | 222 ++++++++++++++++++++++
 tb/tb_mips_alu_mul_div.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_alu_mul_div_pkg.sv
// ----------------------------------------------------------------------------
// mips_alu_mul_div_pkg
// Shared ALU control package. Holds the ALU control typedefs used by the
// execute stage and the HI/LO multiply/divide unit encodings:
//   alu_ctrl_e  - single-cycle ALU function select
//   md_op_e     - multiply/divide/move-to-HI/LO operation select (3 bits)
//   md_state_e  - multiply/divide sequencer states
// Helper functions classify md_op_e encodings (signedness, divide vs multiply).
// ----------------------------------------------------------------------------
package mips_alu_mul_div_pkg;

   // Single-cycle ALU function select.
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_NOR  = 4'd5,
      ALU_SLT  = 4'd6,
      ALU_SLTU = 4'd7,
      ALU_SLL  = 4'd8,
      ALU_SRL  = 4'd9,
      ALU_SRA  = 4'd10,
      ALU_LUI  = 4'd11
   } alu_ctrl_e;

   // HI/LO unit operation select; codes 6 and 7 are reserved and ignored.
   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_e;

   // Multiply/divide sequencer states.
   typedef enum logic [1:0] {
      MD_IDLE  = 2'd0,
      MD_RUN   = 2'd1,
      MD_FIXUP = 2'd2
   } md_state_e;

   // True for the two's-complement operations.
   function automatic logic md_op_is_signed(input logic [2:0] op);
      logic r;
      if ((op == MD_MULT) || (op == MD_DIV)) begin
         r = 1'b1;
      end else begin
         r = 1'b0;
      end
      return r;
   endfunction

   // True for the divide operations.
   function automatic logic md_op_is_div(input logic [2:0] op);
      logic r;
      if ((op == MD_DIV) || (op == MD_DIVU)) begin
         r = 1'b1;
      end else begin
         r = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/mips_alu_mul_div_step.sv
// ----------------------------------------------------------------------------
// mips_alu_mul_div_step
// One combinational iteration of the unsigned multiply/divide datapath.
// The working pair {acc, q} is the 2*WIDTH partial product (multiply) or the
// partial remainder / quotient-in-progress (divide).
//   is_div   in   1 = restoring shift-subtract step, 0 = shift-add step
//   acc      in   upper working word (product high / partial remainder)
//   q        in   lower working word (multiplier bits / dividend-quotient)
//   b        in   multiplicand (multiply) or divisor (divide), unsigned
//   acc_next out  next upper working word
//   q_next   out  next lower working word
// ----------------------------------------------------------------------------
module mips_alu_mul_div_step
   import mips_alu_mul_div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             is_div,
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] acc_next,
   output logic [WIDTH-1:0] q_next
);

   logic [WIDTH:0]   sum_s;
   logic [WIDTH:0]   part_s;
   logic [WIDTH-1:0] diff_s;
   logic             ge_s;

   // Single shift-add or restoring shift-subtract iteration.
   always_comb begin
      // Multiply: add b when the current multiplier LSB is set, then shift
      // the carry-extended pair right by one.
      if (q[0]) begin
         sum_s = {1'b0, acc} + {1'b0, b};
      end else begin
         sum_s = {1'b0, acc};
      end

      // Divide: shift the next dividend bit into the partial remainder and
      // subtract when it fits. The remainder stays below b, so the shifted
      // value needs only one extra bit and the difference fits in WIDTH bits.
      part_s = {acc, q[WIDTH-1]};
      ge_s   = (part_s >= {1'b0, b});
      diff_s = part_s[WIDTH-1:0] - b;

      if (is_div) begin
         if (ge_s) begin
            acc_next = diff_s;
            q_next   = {q[WIDTH-2:0], 1'b1};
         end else begin
            acc_next = part_s[WIDTH-1:0];
            q_next   = {q[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_next = sum_s[WIDTH:1];
         q_next   = {sum_s[0], q[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mips_alu_mul_div.sv
// ----------------------------------------------------------------------------
// mips_alu_mul_div
// Iterative MIPS HI/LO unit: MULT, MULTU, DIV, DIVU (one bit per cycle,
// WIDTH+1 cycles from acceptance to done) plus single-edge MTHI/MTLO.
// Signed operations run on magnitudes; the sign is restored in FIXUP.
//   clock  in   rising-edge clock
//   reset  in   asynchronous active-high reset
//   start  in   request valid, accepted when ready and no flush
//   op     in   md_op_e operation select (6, 7 ignored)
//   a      in   rs: dividend / multiplicand / move source
//   b      in   rt: divisor / multiplier
//   flush  in   cancel the in-flight operation; blocks acceptance
//   ready  out  unit idle
//   done   out  one-cycle pulse after a mul/div result lands in HI/LO
//   hi     out  architectural HI
//   lo     out  architectural LO
// ----------------------------------------------------------------------------
module mips_alu_mul_div
   import mips_alu_mul_div_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int COUNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   md_state_e          state_r, state_n;
   logic [WIDTH-1:0]   hi_r, hi_n;
   logic [WIDTH-1:0]   lo_r, lo_n;
   logic [WIDTH-1:0]   acc_r, acc_n;
   logic [WIDTH-1:0]   q_r, q_n;
   logic [WIDTH-1:0]   b_r, b_n;
   logic [COUNT_W-1:0] cnt_r, cnt_n;
   logic               is_div_r, is_div_n;
   logic               neg_q_r, neg_q_n;
   logic               neg_r_r, neg_r_n;
   logic               done_r, done_n;

   logic               op_signed_s;
   logic [WIDTH-1:0]   a_mag_s;
   logic [WIDTH-1:0]   b_mag_s;
   logic [WIDTH-1:0]   step_acc_s;
   logic [WIDTH-1:0]   step_q_s;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   quot_s;
   logic [WIDTH-1:0]   rem_s;

   mips_alu_mul_div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .is_div   (is_div_r),
      .acc      (acc_r),
      .q        (q_r),
      .b        (b_r),
      .acc_next (step_acc_s),
      .q_next   (step_q_s)
   );

   // Operand magnitudes for acceptance and sign-corrected results for FIXUP.
   always_comb begin
      op_signed_s = md_op_is_signed(op);

      if (op_signed_s && a[WIDTH-1]) begin
         a_mag_s = -a;
      end else begin
         a_mag_s = a;
      end

      if (op_signed_s && b[WIDTH-1]) begin
         b_mag_s = -b;
      end else begin
         b_mag_s = b;
      end

      // neg_q_r doubles as "product sign differs" for multiply.
      if (neg_q_r) begin
         prod_s = -{acc_r, q_r};
         quot_s = -q_r;
      end else begin
         prod_s = {acc_r, q_r};
         quot_s = q_r;
      end

      if (neg_r_r) begin
         rem_s = -acc_r;
      end else begin
         rem_s = acc_r;
      end
   end

   // Sequencer next state and next register values.
   always_comb begin
      state_n  = state_r;
      hi_n     = hi_r;
      lo_n     = lo_r;
      acc_n    = acc_r;
      q_n      = q_r;
      b_n      = b_r;
      cnt_n    = cnt_r;
      is_div_n = is_div_r;
      neg_q_n  = neg_q_r;
      neg_r_n  = neg_r_r;
      done_n   = 1'b0;

      case (state_r)
         MD_IDLE: begin
            if (start && !flush) begin
               case (op)
                  MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                     is_div_n = md_op_is_div(op);
                     neg_q_n  = op_signed_s && (a[WIDTH-1] ^ b[WIDTH-1]);
                     neg_r_n  = op_signed_s && a[WIDTH-1];
                     acc_n    = {WIDTH{1'b0}};
                     cnt_n    = COUNT_W'(WIDTH);
                     state_n  = MD_RUN;
                     if (md_op_is_div(op)) begin
                        q_n = a_mag_s;
                        b_n = b_mag_s;
                     end else begin
                        q_n = b_mag_s;
                        b_n = a_mag_s;
                     end
                  end
                  MD_MTHI: begin
                     hi_n = a;
                  end
                  MD_MTLO: begin
                     lo_n = a;
                  end
                  default: begin
                     state_n = MD_IDLE;
                  end
               endcase
            end else begin
               state_n = MD_IDLE;
            end
         end

         MD_RUN: begin
            if (flush) begin
               state_n = MD_IDLE;
               cnt_n   = {COUNT_W{1'b0}};
            end else begin
               acc_n = step_acc_s;
               q_n   = step_q_s;
               cnt_n = cnt_r - COUNT_W'(1);
               if (cnt_r == COUNT_W'(1)) begin
                  state_n = MD_FIXUP;
               end else begin
                  state_n = MD_RUN;
               end
            end
         end

         MD_FIXUP: begin
            state_n = MD_IDLE;
            cnt_n   = {COUNT_W{1'b0}};
            if (flush) begin
               done_n = 1'b0;
            end else begin
               done_n = 1'b1;
               if (is_div_r) begin
                  lo_n = quot_s;
                  hi_n = rem_s;
               end else begin
                  {hi_n, lo_n} = prod_s;
               end
            end
         end

         default: begin
            state_n = MD_IDLE;
            cnt_n   = {COUNT_W{1'b0}};
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r  <= MD_IDLE;
         hi_r     <= {WIDTH{1'b0}};
         lo_r     <= {WIDTH{1'b0}};
         acc_r    <= {WIDTH{1'b0}};
         q_r      <= {WIDTH{1'b0}};
         b_r      <= {WIDTH{1'b0}};
         cnt_r    <= {COUNT_W{1'b0}};
         is_div_r <= 1'b0;
         neg_q_r  <= 1'b0;
         neg_r_r  <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         state_r  <= state_n;
         hi_r     <= hi_n;
         lo_r     <= lo_n;
         acc_r    <= acc_n;
         q_r      <= q_n;
         b_r      <= b_n;
         cnt_r    <= cnt_n;
         is_div_r <= is_div_n;
         neg_q_r  <= neg_q_n;
         neg_r_r  <= neg_r_n;
         done_r   <= done_n;
      end
   end

   assign ready = (state_r == MD_IDLE);
   assign done  = done_r;
   assign hi    = hi_r;
   assign lo    = lo_r;

endmodule

// File: tb/tb_mips_alu_mul_div.sv
// ----------------------------------------------------------------------------
// tb_mips_alu_mul_div
// Scoreboard bench for mips_alu_mul_div (WIDTH=32). Expected HI/LO results come
// from a plain-arithmetic reference of the MIPS mul/div rules and are queued at
// acceptance; a monitor pops one entry per done pulse and checks HI, LO and the
// cycle the pulse appears.
// ----------------------------------------------------------------------------
module tb_mips_alu_mul_div;
   import mips_alu_mul_div_pkg::*;

   localparam int W = 32;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      int           cyc;
      string        tag;
   } exp_t;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic         flush = 1'b0;
   logic [2:0]   op    = 3'd0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         ready;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int           cyc    = 0;
   int           total  = 0;
   int           passed = 0;
   exp_t         sb_q[$];
   exp_t         mon_e;
   logic [W-1:0] model_hi = '0;
   logic [W-1:0] model_lo = '0;

   mips_alu_mul_div #(.WIDTH(W)) dut (
      .clock (clock),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .flush (flush),
      .ready (ready),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: MIPS HI/LO results computed with 64-bit arithmetic.
   function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [W-1:0] x,
                                              input logic [W-1:0] y);
      longint          sx, sy, sq, sr, sp;
      longint unsigned ux, uy, uq, ur, up;
      logic [63:0]     res;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'd0, x};
      uy = {32'd0, y};
      res = 64'd0;
      case (o)
         MD_MULT: begin
            sp  = sx * sy;
            res = sp;
         end
         MD_MULTU: begin
            up  = ux * uy;
            res = up;
         end
         MD_DIV: begin
            if (y == 32'd0) begin
               res = {x, (sx < 0) ? 32'd1 : 32'hFFFF_FFFF};
            end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
               res = {32'd0, 32'h8000_0000};
            end else begin
               sq  = sx / sy;
               sr  = sx % sy;
               res = {sr[31:0], sq[31:0]};
            end
         end
         MD_DIVU: begin
            if (y == 32'd0) begin
               res = {x, 32'hFFFF_FFFF};
            end else begin
               uq  = ux / uy;
               ur  = ux % uy;
               res = {ur[31:0], uq[31:0]};
            end
         end
         default: res = {model_hi, model_lo};
      endcase
      return res;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding operation.
   always @(negedge clock) begin
      if (!reset && done === 1'b1) begin
         if (sb_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_done: done=1 at cycle %0d, expected no done", cyc);
         end else begin
            mon_e = sb_q.pop_front();
            chk({mon_e.tag, "_hi"}, {32'd0, hi}, {32'd0, mon_e.hi});
            chk({mon_e.tag, "_lo"}, {32'd0, lo}, {32'd0, mon_e.lo});
            chk({mon_e.tag, "_done_cycle"}, 64'(cyc), 64'(mon_e.cyc));
         end
      end
   end

   // Wait (bounded) for ready, present one request for one edge; c0 = cycle
   // number right after the accepting edge.
   task automatic accept_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                            output int c0);
      int n;
      n = 0;
      while (ready !== 1'b1 && n < 200) begin
         @(posedge clock);
         #1;
         n++;
      end
      chk("ready_before_issue", {63'd0, ready}, 64'd1);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(posedge clock);
      #1;
      start = 1'b0;
      c0    = cyc;
   endtask

   task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input string tag);
      int          c0;
      logic [63:0] r;
      exp_t        e;
      accept_op(o, x, y, c0);
      if (o == MD_MTHI) begin
         model_hi = x;
         chk({tag, "_hi"}, {32'd0, hi}, {32'd0, model_hi});
         chk({tag, "_ready"}, {63'd0, ready}, 64'd1);
      end else if (o == MD_MTLO) begin
         model_lo = x;
         chk({tag, "_lo"}, {32'd0, lo}, {32'd0, model_lo});
         chk({tag, "_ready"}, {63'd0, ready}, 64'd1);
      end else begin
         r     = ref_result(o, x, y);
         e.hi  = r[63:32];
         e.lo  = r[31:0];
         e.cyc = c0 + W + 1;
         e.tag = tag;
         sb_q.push_back(e);
         model_hi = r[63:32];
         model_lo = r[31:0];
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int           c0;
      int           n;
      logic [2:0]   ro;
      logic [W-1:0] ra, rb;
      logic [W-1:0] old_hi, old_lo;

      // Asynchronous reset before any clock edge.
      #2 reset = 1'b1;
      #1;
      chk("reset_hi", {32'd0, hi}, 64'd0);
      chk("reset_lo", {32'd0, lo}, 64'd0);
      chk("reset_ready", {63'd0, ready}, 64'd1);
      chk("reset_done", {63'd0, done}, 64'd0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      // Directed cases, including divide-by-zero and overflow boundaries.
      issue(MD_MULT,  32'hFFFF_FFFD, 32'd5,         "mult_m3x5");
      issue(MD_DIVU,  32'd100,       32'd7,         "divu_100_7");
      issue(MD_DIV,   32'hFFFF_FFF9, 32'd2,         "div_m7_2");
      issue(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
      issue(MD_DIVU,  32'd9,         32'd0,         "divu_9_0");
      issue(MD_DIV,   32'hFFFF_FFF7, 32'd0,         "div_m9_0");
      issue(MD_DIV,   32'd9,         32'd0,         "div_9_0");
      issue(MD_MULT,  32'h8000_0000, 32'h8000_0000, "mult_min_min");
      issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max_max");
      issue(MD_DIV,   32'd7,         32'hFFFF_FFFE, "div_7_m2");

      // Randomised operations against the reference.
      for (int i = 0; i < 40; i++) begin
         ro = 3'($urandom_range(0, 3));
         ra = (($urandom_range(0, 7)) == 0) ? 32'h8000_0000 : 32'($urandom);
         case ($urandom_range(0, 7))
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(1, 15));
            2:       rb = 32'hFFFF_FFFF;
            default: rb = 32'($urandom);
         endcase
         issue(ro, ra, rb, "random");
      end

      // Flush in cycle 10 of a MULTU: back to idle in cycle 11, HI/LO kept.
      old_hi = model_hi;
      old_lo = model_lo;
      accept_op(MD_MULTU, 32'hDEAD_BEEF, 32'h1234_5678, c0);
      chk("flush_busy", {63'd0, ready}, 64'd0);
      repeat (9) @(posedge clock);
      #1;
      chk("flush_busy_cycle10", {63'd0, ready}, 64'd0);
      flush = 1'b1;
      @(posedge clock);
      #1;
      flush = 1'b0;
      chk("flush_ready_cycle11", {63'd0, ready}, 64'd1);
      chk("flush_hi_kept", {32'd0, hi}, {32'd0, old_hi});
      chk("flush_lo_kept", {32'd0, lo}, {32'd0, old_lo});
      repeat (40) @(posedge clock);
      #1;

      // Start and flush together: not accepted.
      start = 1'b1;
      flush = 1'b1;
      op    = MD_DIV;
      a     = 32'd50;
      b     = 32'd3;
      @(posedge clock);
      #1;
      start = 1'b0;
      flush = 1'b0;
      chk("start_flush_not_accepted", {63'd0, ready}, 64'd1);
      repeat (40) @(posedge clock);
      #1;
      chk("start_flush_hi_kept", {32'd0, hi}, {32'd0, old_hi});
      chk("start_flush_lo_kept", {32'd0, lo}, {32'd0, old_lo});

      // MTHI while busy is ignored; MTLO after done lands on the next edge.
      old_hi = model_hi;
      issue(MD_DIVU, 32'd1000, 32'd33, "divu_busy");
      start = 1'b1;
      op    = MD_MTHI;
      a     = 32'h0000_1234;
      repeat (3) @(posedge clock);
      #1;
      start = 1'b0;
      chk("mthi_busy_ready", {63'd0, ready}, 64'd0);
      chk("mthi_busy_hi_kept", {32'd0, hi}, {32'd0, old_hi});
      issue(MD_MTLO, 32'h0000_0055, 32'd0, "mtlo_after_done");
      chk("mtlo_hi_is_div_rem", {32'd0, hi}, {32'd0, model_hi});
      issue(MD_MTHI, 32'hCAFE_F00D, 32'd0, "mthi_idle");

      // Reserved op codes change nothing.
      accept_op(3'd6, 32'h1111_1111, 32'd0, c0);
      chk("op6_ready", {63'd0, ready}, 64'd1);
      accept_op(3'd7, 32'h2222_2222, 32'd0, c0);
      chk("op7_ready", {63'd0, ready}, 64'd1);
      chk("reserved_hi_kept", {32'd0, hi}, {32'd0, model_hi});
      chk("reserved_lo_kept", {32'd0, lo}, {32'd0, model_lo});

      // Reset between edges mid-RUN: immediate clear, no done afterwards.
      issue(MD_MULT, 32'd1234, 32'd5678, "mult_reset");
      repeat (5) @(posedge clock);
      #3;
      reset = 1'b1;
      sb_q.delete();
      model_hi = '0;
      model_lo = '0;
      #1;
      chk("midrun_reset_hi", {32'd0, hi}, 64'd0);
      chk("midrun_reset_lo", {32'd0, lo}, 64'd0);
      chk("midrun_reset_ready", {63'd0, ready}, 64'd1);
      chk("midrun_reset_done", {63'd0, done}, 64'd0);
      @(posedge clock);
      #1 reset = 1'b0;
      repeat (40) @(posedge clock);
      #1;
      chk("post_reset_hi", {32'd0, hi}, 64'd0);
      chk("post_reset_lo", {32'd0, lo}, 64'd0);

      // One more operation after reset, then drain the scoreboard.
      issue(MD_DIV, 32'hFFFF_FF9C, 32'd7, "div_after_reset");
      n = 0;
      while (sb_q.size() != 0 && n < 100) begin
         @(posedge clock);
         #1;
         n++;
      end
      chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

      repeat (2) @(posedge clock);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
